// File: rtl/mult_div_pkg.sv
// Shared types and constants for the multicycle multiply/divide unit.
package mult_div_pkg;

  localparam int unsigned MD_WIDTH = 32;
  localparam int unsigned MD_CNT_W = $clog2(MD_WIDTH + 1);

  typedef enum logic [2:0] {
    StIdle,
    StMult,
    StDiv,
    StFix,
    StDzero
  } md_state_e;

endpackage

// File: rtl/booth_mult_core.sv
// One combinational radix-2 Booth step on the {acc, mplr, q_m1} register.
module booth_mult_core
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic [WIDTH+1:0] acc,
  input  logic [WIDTH-1:0] mplr,
  input  logic             q_m1,
  input  logic [WIDTH+1:0] mcand,
  output logic [WIDTH+1:0] acc_next,
  output logic [WIDTH-1:0] mplr_next,
  output logic             q_m1_next
);

  logic [WIDTH+1:0] sum;

  always_comb begin
    case ({mplr[0], q_m1})
      2'b01:   sum = acc + mcand;
      2'b10:   sum = acc - mcand;
      default: sum = acc;
    endcase
    acc_next  = {sum[WIDTH+1], sum[WIDTH+1:1]};
    mplr_next = {sum[0], mplr[WIDTH-1:1]};
    q_m1_next = mplr[0];
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (Booth) / divide (restoring) engine with hi/lo result.
// Optional MULTDIV_UNSIGNED_EN adds an is_unsigned input for multu/divu.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MULT_on,
  input  logic             DIV_on,
`ifdef MULTDIV_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  md_state_e        state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH+1:0] acc_q, mcand_q;
  logic [WIDTH-1:0] mplr_q;
  logic             qm1_q, is_mult_q, corr_q, qneg_q, rneg_q;

  logic             uns_in;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   partial;
  logic [WIDTH+1:0] trial;
  logic [WIDTH+1:0] b_acc;
  logic [WIDTH-1:0] b_mplr;
  logic             b_qm1;
  logic             last_step;

`ifdef MULTDIV_UNSIGNED_EN
  assign uns_in = is_unsigned;
`else
  assign uns_in = 1'b0;
`endif

  assign a_mag     = (!uns_in && op_a[WIDTH-1]) ? -op_a : op_a;
  assign b_mag     = (!uns_in && op_b[WIDTH-1]) ? -op_b : op_b;
  // Division reuses acc_q as the partial remainder and mplr_q as dividend/quotient.
  assign partial   = {acc_q[WIDTH-1:0], mplr_q[WIDTH-1]};
  assign trial     = {1'b0, partial} - {2'b00, mcand_q[WIDTH-1:0]};
  assign last_step = (cnt_q == CntW'(WIDTH - 1));

  booth_mult_core #(.WIDTH(WIDTH)) u_booth (
    .acc       (acc_q),
    .mplr      (mplr_q),
    .q_m1      (qm1_q),
    .mcand     (mcand_q),
    .acc_next  (b_acc),
    .mplr_next (b_mplr),
    .q_m1_next (b_qm1)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      qm1_q     <= 1'b0;
      is_mult_q <= 1'b0;
      corr_q    <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (MULT_on) begin
            acc_q     <= '0;
            mcand_q   <= uns_in ? {2'b00, op_a} : {{2{op_a[WIDTH-1]}}, op_a};
            mplr_q    <= op_b;
            qm1_q     <= 1'b0;
            is_mult_q <= 1'b1;
            // Booth reads the multiplier as signed; unsigned needs +a<<WIDTH when b's MSB is set.
            corr_q    <= uns_in & op_b[WIDTH-1];
            busy      <= 1'b1;
            state_q   <= StMult;
          end else if (DIV_on && op_b != '0) begin
            acc_q     <= '0;
            mcand_q   <= {2'b00, b_mag};
            mplr_q    <= a_mag;
            is_mult_q <= 1'b0;
            qneg_q    <= !uns_in && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            rneg_q    <= !uns_in && op_a[WIDTH-1];
            busy      <= 1'b1;
            state_q   <= StDiv;
          end else if (DIV_on) begin
            state_q <= StDzero;
          end
        end
        StMult: begin
          acc_q  <= b_acc;
          mplr_q <= b_mplr;
          qm1_q  <= b_qm1;
          cnt_q  <= cnt_q + CntW'(1);
          if (last_step) state_q <= StFix;
        end
        StDiv: begin
          if (!trial[WIDTH+1]) begin
            acc_q  <= {1'b0, trial[WIDTH:0]};
            mplr_q <= {mplr_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_q  <= {1'b0, partial};
            mplr_q <= {mplr_q[WIDTH-2:0], 1'b0};
          end
          cnt_q <= cnt_q + CntW'(1);
          if (last_step) state_q <= StFix;
        end
        StFix: begin
          if (is_mult_q) begin
            hi <= acc_q[WIDTH-1:0] + (corr_q ? mcand_q[WIDTH-1:0] : '0);
            lo <= mplr_q;
          end else begin
            hi <= rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            lo <= qneg_q ? -mplr_q : mplr_q;
          end
          cnt_q   <= '0;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        StDzero: begin
          div_zero <= 1'b1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (signed default build).
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MULT_on, DIV_on;
  logic [31:0] op_a, op_b, hi, lo;
  logic        busy, done, div_zero;
`ifdef MULTDIV_UNSIGNED_EN
  logic        is_unsigned = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk      (clk),
    .reset    (reset),
    .MULT_on  (MULT_on),
    .DIV_on   (DIV_on),
`ifdef MULTDIV_UNSIGNED_EN
    .is_unsigned (is_unsigned),
`endif
    .op_a     (op_a),
    .op_b     (op_b),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  // Drive one start pulse across edge 0; returns 1 ns after that edge.
  task automatic start(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    MULT_on = m; DIV_on = d; op_a = a; op_b = b;
    @(posedge clk); #1;
    MULT_on = 1'b0; DIV_on = 1'b0;
  endtask

  // Cycle index (edges after start) at which done is seen; 0 on timeout.
  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 40 && cyc == 0; i++) begin
      @(posedge clk); #1;
      if (done) cyc = i;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; MULT_on = 1'b0; DIV_on = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({hi, lo} !== 64'h0) begin
      errors++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo});
    end
    checks++;
    if ({busy, done, div_zero} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {busy, done, div_zero});
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_mult();
    logic [31:0] va[5]  = '{32'd7, 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] vb[5]  = '{32'hFFFFFFFD, 32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ehi[5] = '{32'hFFFFFFFF, 32'h40000000, 32'h3FFFFFFF, 32'hC0000000, 32'h0};
    logic [31:0] elo[5] = '{32'hFFFFFFEB, 32'h0, 32'h00000001, 32'h80000000, 32'h1};
    int cyc;
    for (int k = 0; k < 5; k++) begin
      start(1'b1, 1'b0, va[k], vb[k]);
      if (k == 0) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("FAIL mult_busy: got %b expected 1", busy);
        end
      end
      wait_done(cyc);
      checks++;
      if (cyc !== 33) begin
        errors++; $display("FAIL mult%0d_latency: got %0d expected 33", k, cyc);
      end
      checks++;
      if (hi !== ehi[k] || lo !== elo[k]) begin
        errors++;
        $display("FAIL mult%0d_result: got %h_%h expected %h_%h", k, hi, lo, ehi[k], elo[k]);
      end
      if (k == 0) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++; $display("FAIL mult_busy_at_done: got %b expected 0", busy);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
          errors++; $display("FAIL mult_done_pulse: got %b expected 0", done);
        end
      end
    end
  endtask

  task automatic test_div();
    logic [31:0] va[6]  = '{32'hFFFFFFF9, 32'h80000000, 32'd7, 32'd100, 32'hFFFFFF9C, 32'd3};
    logic [31:0] vb[6]  = '{32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd7, 32'hFFFFFFF9, 32'd5};
    logic [31:0] ehi[6] = '{32'hFFFFFFFF, 32'h0, 32'h1, 32'd2, 32'hFFFFFFFE, 32'd3};
    logic [31:0] elo[6] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFD, 32'd14, 32'd14, 32'd0};
    int cyc;
    for (int k = 0; k < 6; k++) begin
      start(1'b0, 1'b1, va[k], vb[k]);
      wait_done(cyc);
      checks++;
      if (cyc !== 33) begin
        errors++; $display("FAIL div%0d_latency: got %0d expected 33", k, cyc);
      end
      checks++;
      if (hi !== ehi[k] || lo !== elo[k]) begin
        errors++;
        $display("FAIL div%0d_result: got %h_%h expected %h_%h", k, hi, lo, ehi[k], elo[k]);
      end
    end
  endtask

  task automatic test_div_zero();
    int cyc, ndone, nz;
    start(1'b0, 1'b1, 32'd68, 32'd7);
    wait_done(cyc);
    checks++;
    if (hi !== 32'd5 || lo !== 32'd9) begin
      errors++; $display("FAIL dz_setup: got %h_%h expected 5_9", hi, lo);
    end
    start(1'b0, 1'b1, 32'd123, 32'd0);
    checks++;
    if (div_zero !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL dz_edge0: got dz=%b busy=%b expected 0 0", div_zero, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (div_zero !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL dz_edge1: got dz=%b busy=%b expected 1 0", div_zero, busy);
    end
    ndone = 0; nz = 0;
    for (int i = 2; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
      if (div_zero) nz++;
    end
    checks++;
    if (ndone !== 0 || nz !== 0) begin
      errors++; $display("FAIL dz_after: got done=%0d dz=%0d expected 0 0", ndone, nz);
    end
    checks++;
    if (hi !== 32'd5 || lo !== 32'd9) begin
      errors++; $display("FAIL dz_hold: got %h_%h expected 5_9", hi, lo);
    end
  endtask

  task automatic test_ignored_starts();
    int first, ndone, nz, cyc;
    start(1'b1, 1'b0, 32'd7, 32'd3);
    first = 0; ndone = 0; nz = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      DIV_on  = (i == 5);
      MULT_on = (i == 20);
      if (i == 5)  begin op_a = 32'd50;  op_b = 32'd0; end
      if (i == 20) begin op_a = 32'd100; op_b = 32'd9; end
      @(posedge clk); #1;
      if (done) begin ndone++; if (first == 0) first = i; end
      if (div_zero) nz++;
    end
    MULT_on = 1'b0; DIV_on = 1'b0;
    checks++;
    if (ndone !== 1 || first !== 33 || nz !== 0) begin
      errors++;
      $display("FAIL busy_ignore: got done=%0d at %0d dz=%0d expected 1 at 33 dz 0", ndone, first, nz);
    end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd21) begin
      errors++; $display("FAIL busy_ignore_result: got %h_%h expected 0_15", hi, lo);
    end
    start(1'b1, 1'b1, 32'd6, 32'd5);
    wait_done(cyc);
    checks++;
    if (cyc !== 33 || hi !== 32'd0 || lo !== 32'd30) begin
      errors++;
      $display("FAIL both_strobes: got cyc=%0d %h_%h expected 33 0_1e", cyc, hi, lo);
    end
  endtask

  task automatic test_reset_mid_op();
    int cyc;
    start(1'b0, 1'b1, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got %h_%h busy=%b done=%b expected 0_0 0 0", hi, lo, busy, done);
    end
    @(negedge clk); reset = 1'b0;
    start(1'b0, 1'b1, 32'd100, 32'd7);
    wait_done(cyc);
    checks++;
    if (cyc !== 33 || hi !== 32'd2 || lo !== 32'd14) begin
      errors++;
      $display("FAIL reset_recover: got cyc=%0d %h_%h expected 33 2_e", cyc, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    start(1'b1, 1'b0, 32'hFFFFFFFE, 32'd3);
    wait_done(cyc);
    checks++;
    if (cyc !== 33 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
      errors++;
      $display("FAIL b2b_first: got cyc=%0d %h_%h expected 33 ffffffff_fffffffa", cyc, hi, lo);
    end
    // Next start lands on the edge right after done.
    start(1'b0, 1'b1, 32'hFFFFFFF5, 32'd3);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL b2b_accept: got busy=%b expected 1", busy);
    end
    wait_done(cyc);
    checks++;
    if (cyc !== 33 || hi !== 32'hFFFFFFFE || lo !== 32'hFFFFFFFD) begin
      errors++;
      $display("FAIL b2b_second: got cyc=%0d %h_%h expected 33 fffffffe_fffffffd", cyc, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_ignored_starts();
    test_reset_mid_op();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
